// File: rtl/alu_stream_unit.sv
// -----------------------------------------------------------------------------
// alu_stream_unit
//
// Two-stage pipelined ALU with valid/ready on both sides. S1 captures the
// request operands. S2 captures the computed result and drives the response.
// Two saturating counters track delivered responses and illegal responses.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   req_valid    request present
//   req_ready    unit accepts the request this cycle (combinational from rsp_ready)
//   req_a/req_b  operands, WIDTH bits
//   req_ctrl     4-bit ALUControl code
//   req_tag      request tag, carried through unchanged
//   rsp_valid    response present
//   rsp_ready    consumer accepts the response
//   rsp_result   ALU result
//   rsp_zero     result == 0
//   rsp_illegal  ctrl code was unsupported (result forced to 0)
//   rsp_tag      tag of the request
//   done_cnt     responses delivered (saturating)
//   illegal_cnt  illegal responses delivered (saturating)
// -----------------------------------------------------------------------------
module alu_stream_unit #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [3:0]       req_ctrl,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_illegal,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [CNT_W-1:0] done_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [3:0]       s1_ctrl_q, s1_ctrl_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_result_q, s2_result_d;
    logic             s2_zero_q, s2_zero_d;
    logic             s2_illegal_q, s2_illegal_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
    logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

    logic             s2_free;
    logic             s1_adv;
    logic             req_fire;
    logic             rsp_fire;
    logic [WIDTH-1:0] alu_result;
    logic             alu_illegal;

    // Handshake control. req_ready is combinational from rsp_ready so that
    // a full pipe can accept a new request in the same cycle it drains.
    always_comb begin
        s2_free  = ~s2_valid_q | rsp_ready;
        s1_adv   = s1_valid_q & s2_free;
        req_ready = ~s1_valid_q | s2_free;
        req_fire = req_valid & req_ready;
        rsp_fire = s2_valid_q & rsp_ready;
    end

    // ALU on the S1 registers; arithmetic wraps modulo 2^WIDTH.
    always_comb begin
        alu_result  = '0;
        alu_illegal = 1'b0;
        case (s1_ctrl_q)
            OP_AND:  alu_result = s1_a_q & s1_b_q;
            OP_OR:   alu_result = s1_a_q | s1_b_q;
            OP_ADD:  alu_result = s1_a_q + s1_b_q;
            OP_SUB:  alu_result = s1_a_q - s1_b_q;
            OP_PASS: alu_result = s1_b_q;
            OP_NOR:  alu_result = ~(s1_a_q | s1_b_q);
            default: alu_illegal = 1'b1;
        endcase
    end

    // Next-state for both stages and the counters.
    always_comb begin
        // S1: load on accept, otherwise empty out when it advances.
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_ctrl_d  = s1_ctrl_q;
        s1_tag_d   = s1_tag_q;
        if (req_fire) begin
            s1_valid_d = 1'b1;
            s1_a_d     = req_a;
            s1_b_d     = req_b;
            s1_ctrl_d  = req_ctrl;
            s1_tag_d   = req_tag;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        // S2: load when S1 advances, otherwise clear once consumed.
        s2_valid_d   = s2_valid_q;
        s2_result_d  = s2_result_q;
        s2_zero_d    = s2_zero_q;
        s2_illegal_d = s2_illegal_q;
        s2_tag_d     = s2_tag_q;
        if (s1_adv) begin
            s2_valid_d   = 1'b1;
            s2_result_d  = alu_result;
            s2_zero_d    = (alu_result == '0);
            s2_illegal_d = alu_illegal;
            s2_tag_d     = s1_tag_q;
        end else if (rsp_fire) begin
            s2_valid_d = 1'b0;
        end

        done_cnt_d    = done_cnt_q;
        illegal_cnt_d = illegal_cnt_q;
        if (rsp_fire) begin
            done_cnt_d = sat_inc(done_cnt_q);
            if (s2_illegal_q) begin
                illegal_cnt_d = sat_inc(illegal_cnt_q);
            end
        end
    end

    // ---- stage boundary S1: request capture (data needs no reset) ----
    always_ff @(posedge clk) begin
        s1_a_q    <= s1_a_d;
        s1_b_q    <= s1_b_d;
        s1_ctrl_q <= s1_ctrl_d;
        s1_tag_q  <= s1_tag_d;
    end

    // ---- stage boundary S2 and control: response outputs clear on reset ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q    <= 1'b0;
            s2_valid_q    <= 1'b0;
            s2_result_q   <= '0;
            s2_zero_q     <= 1'b0;
            s2_illegal_q  <= 1'b0;
            s2_tag_q      <= '0;
            done_cnt_q    <= '0;
            illegal_cnt_q <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s2_valid_q    <= s2_valid_d;
            s2_result_q   <= s2_result_d;
            s2_zero_q     <= s2_zero_d;
            s2_illegal_q  <= s2_illegal_d;
            s2_tag_q      <= s2_tag_d;
            done_cnt_q    <= done_cnt_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign rsp_valid   = s2_valid_q;
    assign rsp_result  = s2_result_q;
    assign rsp_zero    = s2_zero_q;
    assign rsp_illegal = s2_illegal_q;
    assign rsp_tag     = s2_tag_q;
    assign done_cnt    = done_cnt_q;
    assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_alu_stream_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_stream_unit
//
// Drives alu_stream_unit from a vector table and from a few hand-written
// sequences. Expected responses go into a queue when a request is accepted.
// A monitor pops that queue and compares each delivered response.
// A second instance with 4-bit counters shares the stimulus. It is used to
// observe counter saturation.
// -----------------------------------------------------------------------------
module tb_alu_stream_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_ctrl;
    logic [3:0]  req_tag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_illegal;
    logic [3:0]  rsp_tag;
    logic [15:0] done_cnt;
    logic [15:0] illegal_cnt;

    logic        sm_req_ready;
    logic        sm_rsp_valid;
    logic [63:0] sm_rsp_result;
    logic        sm_rsp_zero;
    logic        sm_rsp_illegal;
    logic [3:0]  sm_rsp_tag;
    logic [3:0]  sm_done_cnt;
    logic [3:0]  sm_illegal_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_stream_unit dut (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .rsp_illegal(rsp_illegal), .rsp_tag(rsp_tag),
        .done_cnt(done_cnt), .illegal_cnt(illegal_cnt)
    );

    alu_stream_unit #(.WIDTH(64), .TAG_W(4), .CNT_W(4)) dut_sm (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid), .req_ready(sm_req_ready),
        .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl), .req_tag(req_tag),
        .rsp_valid(sm_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(sm_rsp_result), .rsp_zero(sm_rsp_zero),
        .rsp_illegal(sm_rsp_illegal), .rsp_tag(sm_rsp_tag),
        .done_cnt(sm_done_cnt), .illegal_cnt(sm_illegal_cnt)
    );

    typedef struct {
        logic [63:0] res;
        logic        zero;
        logic        ill;
        logic [3:0]  tag;
        int          acc;  // clock edge on which the request was accepted
        bit          lat;  // check the unstalled two-edge latency
    } exp_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  ctrl;
        logic [63:0] res;
        logic        ill;
    } vec_t;

    exp_t sb[$];
    vec_t vt[9];

    // Independent reference for the randomised run.
    function automatic void alu_model(input logic [63:0] a, input logic [63:0] b,
                                      input logic [3:0] c,
                                      output logic [63:0] res, output logic ill);
        ill = 1'b0;
        res = 64'd0;
        case (c)
            4'b0000: res = a & b;
            4'b0001: res = a | b;
            4'b0010: res = a + b;
            4'b0110: res = a - b;
            4'b0111: res = b;
            4'b1100: res = ~(a | b);
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present one request, wait (bounded) for acceptance, record the expectation.
    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [3:0] c,
                        input logic [3:0] t, input logic [63:0] er, input logic ei,
                        input bit lat);
        bit ok;
        exp_t e;
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        req_ctrl = c;
        req_tag = t;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            e.res = er;
            e.zero = (er == 64'd0);
            e.ill = ei;
            e.tag = t;
            e.acc = cyc + 1;
            e.lat = lat;
            sb.push_back(e);
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: tag %0h not accepted in 20 cycles", t);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Wait (bounded) until every expected response has been delivered.
    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got result %0h tag %0h, expected no response",
                             rsp_result, rsp_tag);
                end else begin
                    e = sb.pop_front();
                    if (rsp_result !== e.res || rsp_zero !== e.zero ||
                        rsp_illegal !== e.ill || rsp_tag !== e.tag) begin
                        errors++;
                        $display("FAIL rsp_data: got res=%0h z=%0b ill=%0b tag=%0h, expected res=%0h z=%0b ill=%0b tag=%0h",
                                 rsp_result, rsp_zero, rsp_illegal, rsp_tag,
                                 e.res, e.zero, e.ill, e.tag);
                    end
                    if (e.lat) begin
                        checks++;
                        if (cyc + 1 != e.acc + 2) begin
                            errors++;
                            $display("FAIL rsp_latency: got %0d edges, expected 2", cyc + 1 - e.acc);
                        end
                    end
                end
            end
        end
    endtask

    logic [3:0] codes [7];
    logic [63:0] ma, mb, mres;
    logic mill;

    initial begin
        fork
            monitor();
            begin
                #100000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        vt[0] = '{64'd3, 64'd3, 4'b0000, 64'd3, 1'b0};
        vt[1] = '{64'd3, 64'd3, 4'b0001, 64'd3, 1'b0};
        vt[2] = '{64'd3, 64'd3, 4'b0010, 64'd6, 1'b0};
        vt[3] = '{64'd3, 64'd3, 4'b0110, 64'd0, 1'b0};
        vt[4] = '{64'd3, 64'd3, 4'b0111, 64'd3, 1'b0};
        vt[5] = '{64'd3, 64'd3, 4'b1100, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        vt[6] = '{64'd3, 64'd3, 4'b1111, 64'd0, 1'b1};
        vt[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 64'd0, 1'b0};
        vt[8] = '{64'd0, 64'd1, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1111};

        rst_n = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        req_a = '0;
        req_b = '0;
        req_ctrl = '0;
        req_tag = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset_rsp_result", rsp_result, 64'd0);
        chk("reset_rsp_zero", {63'd0, rsp_zero}, 64'd0);
        chk("reset_rsp_illegal", {63'd0, rsp_illegal}, 64'd0);
        chk("reset_rsp_tag", {60'd0, rsp_tag}, 64'd0);
        chk("reset_done_cnt", {48'd0, done_cnt}, 64'd0);
        chk("reset_illegal_cnt", {48'd0, illegal_cnt}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_req_ready", {63'd0, req_ready}, 64'd1);

        // Six legal ops back-to-back.
        for (int i = 0; i < 6; i++)
            send(vt[i].a, vt[i].b, vt[i].ctrl, 4'(i), vt[i].res, vt[i].ill, 1'b1);
        drain();
        chk("done_cnt_after_6", {48'd0, done_cnt}, 64'd6);
        chk("illegal_cnt_after_6", {48'd0, illegal_cnt}, 64'd0);

        // Illegal code and wrap-around cases.
        @(posedge clk);
        #1;
        for (int i = 6; i < 9; i++)
            send(vt[i].a, vt[i].b, vt[i].ctrl, 4'(i), vt[i].res, vt[i].ill, 1'b1);
        drain();
        chk("done_cnt_after_9", {48'd0, done_cnt}, 64'd9);
        chk("illegal_cnt_after_9", {48'd0, illegal_cnt}, 64'd1);

        // Backpressure: only two requests fit while the consumer stalls.
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        send(64'd10, 64'd5, 4'b0010, 4'hA, 64'd15, 1'b0, 1'b0);
        send(64'd20, 64'd5, 4'b0010, 4'hB, 64'd25, 1'b0, 1'b0);
        req_valid = 1'b1;
        req_a = 64'd30;
        req_b = 64'd5;
        req_ctrl = 4'b0010;
        req_tag = 4'hC;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("stall_req_ready", {63'd0, req_ready}, 64'd0);
            chk("stall_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("stall_rsp_result", rsp_result, 64'd15);
            chk("stall_rsp_tag", {60'd0, rsp_tag}, 64'hA);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        send(64'd30, 64'd5, 4'b0010, 4'hC, 64'd35, 1'b0, 1'b0);
        send(64'd40, 64'd5, 4'b0010, 4'hD, 64'd45, 1'b0, 1'b0);
        drain();
        chk("done_cnt_after_bp", {48'd0, done_cnt}, 64'd13);

        // Asynchronous reset with two ops in flight.
        @(posedge clk);
        #1;
        send(64'd1, 64'd2, 4'b0010, 4'h1, 64'd3, 1'b0, 1'b0);
        send(64'd1, 64'd3, 4'b0010, 4'h2, 64'd4, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("async_rst_rsp_result", rsp_result, 64'd0);
        chk("async_rst_done_cnt", {48'd0, done_cnt}, 64'd0);
        chk("async_rst_illegal_cnt", {48'd0, illegal_cnt}, 64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(64'd7, 64'd8, 4'b0010, 4'h5, 64'd15, 1'b0, 1'b1);
        drain();
        chk("post_rst_done_cnt", {48'd0, done_cnt}, 64'd1);

        // Twenty mixed ops; the 4-bit counter instance must stick at 15.
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            ma = {$urandom, $urandom};
            mb = {$urandom, $urandom};
            alu_model(ma, mb, codes[i % 7], mres, mill);
            send(ma, mb, codes[i % 7], 4'(i), mres, mill, 1'b1);
        end
        drain();
        chk("sat_big_done_cnt", {48'd0, done_cnt}, 64'd21);
        chk("sat_big_illegal_cnt", {48'd0, illegal_cnt}, 64'd2);
        chk("sat_small_done_cnt", {60'd0, sm_done_cnt}, 64'd15);
        chk("sat_small_illegal_cnt", {60'd0, sm_illegal_cnt}, 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
